// File: rtl/speed_pkg.sv
// speed_pkg
// Shared definitions for the speed selector and the 7-segment speed decoder.
// Holds the speed-code constants, the FSM state type built from them, the
// default debounce length, and a helper that sizes the debounce counter.
// No ports (package).
package speed_pkg;

  // Speed codes as driven on {A,B}; the decoder uses the same constants.
  localparam logic [1:0] SPD_STOP = 2'b00;
  localparam logic [1:0] SPD_SLOW = 2'b01;
  localparam logic [1:0] SPD_FAST = 2'b10;

  localparam int unsigned DEBOUNCE_DEFAULT = 16;

  // State encoding is the speed code itself, so {A,B} comes straight off the
  // state flops with no decode logic in between.
  typedef enum logic [1:0] {
    ST_STOP = SPD_STOP,
    ST_SLOW = SPD_SLOW,
    ST_FAST = SPD_FAST
  } speed_state_e;

  // Bits needed to hold the values 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// Conditions one raw push button: 2-flop synchronizer, debounce counter and
// a registered one-cycle pulse on each accepted press (0->1 of the debounced
// level). Releases produce no pulse; a held button produces one pulse.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   btn_raw  in   raw button level, asynchronous to clk
//   press    out  one-cycle registered press pulse
module btn_debounce
  import speed_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          deb_q, deb_d;
  logic          deb_dly_q, deb_dly_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronized level disagrees with the
  // debounced level. The edge on which it would reach DEBOUNCE_CYCLES is the
  // edge the new level is accepted; the counter returns to zero on that same
  // edge because both levels agree again, so a bounce straight after an
  // accept has to earn its full count before it can flip the level back.
  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    cnt_d     = cnt_q;
    deb_d     = deb_q;
    deb_dly_d = deb_q;
    press_d   = deb_q & ~deb_dly_q;

    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      deb_d = sync2_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      press_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_dly_d;
      press_q   <= press_d;
      cnt_q     <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/speed_sel_enc.sv
// speed_sel_enc
// Three-button speed selector. Debounced up/down/stop presses step a
// STOP/SLOW/FAST state machine whose state drives the 7-segment speed decoder
// directly as {A,B}. spd_chg pulses for one cycle whenever {A,B} moves.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   btn_up    in   raw speed-up button
//   btn_down  in   raw speed-down button
//   btn_stop  in   raw stop button
//   A         out  speed code MSB
//   B         out  speed code LSB
//   spd_chg   out  one-cycle pulse when {A,B} changes
module speed_sel_enc
  import speed_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_stop,
  output logic A,
  output logic B,
  output logic spd_chg
);

  logic up_press, down_press, stop_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_up),
    .press   (up_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_down),
    .press   (down_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_stop (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_stop),
    .press   (stop_press)
  );

  speed_state_e state_q, state_d;
  logic         spd_chg_q, spd_chg_d;

  // Stop wins over everything; up and down together cancel; otherwise step
  // one speed in the pressed direction and saturate at either end.
  // spd_chg is registered alongside the state so it lines up with the cycle
  // in which {A,B} first shows the new value.
  always_comb begin
    state_d = state_q;

    if (stop_press) begin
      state_d = ST_STOP;
    end else if (up_press && !down_press) begin
      unique case (state_q)
        ST_STOP: state_d = ST_SLOW;
        ST_SLOW: state_d = ST_FAST;
        ST_FAST: state_d = ST_FAST;
        default: state_d = ST_STOP;
      endcase
    end else if (down_press && !up_press) begin
      unique case (state_q)
        ST_STOP: state_d = ST_STOP;
        ST_SLOW: state_d = ST_STOP;
        ST_FAST: state_d = ST_SLOW;
        default: state_d = ST_STOP;
      endcase
    end

    spd_chg_d = (state_d != state_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_STOP;
      spd_chg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      spd_chg_q <= spd_chg_d;
    end
  end

  assign A       = state_q[1];
  assign B       = state_q[0];
  assign spd_chg = spd_chg_q;

endmodule

// File: tb/tb_speed_sel_enc.sv
// tb_speed_sel_enc
// Self-checking bench for speed_sel_enc with DEBOUNCE_CYCLES=4. Directed
// scenarios check latency, saturation, priority and reset behaviour against
// fixed expectations; a randomized phase is checked every cycle against a
// behavioural model that tracks raw-level run lengths and a numeric speed.
module tb_speed_sel_enc;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst;
  logic btn_up, btn_down, btn_stop;
  logic A, B, spd_chg;

  int errCount   = 0;
  int checkCount = 0;
  int chgSeen    = 0;

  speed_sel_enc #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_stop (btn_stop),
    .A        (A),
    .B        (B),
    .spd_chg  (spd_chg)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports any disagreement.
  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural reference: a raw level reaches the debouncer two edges after
  // it is sampled, must then disagree with the accepted level for DEB edges
  // in a row to be accepted, and an accepted press moves the speed two edges
  // later. Speed is kept as a number 0..2 whose value equals the {A,B} code.
  logic [2:0] h1 = '0, h2 = '0, deb = '0, p1 = '0, p2 = '0, acc;
  int         run[3] = '{0, 0, 0};
  int         spd = 0, oldSpd;
  logic       expChg = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      h1 = '0; h2 = '0; deb = '0; p1 = '0; p2 = '0;
      run = '{0, 0, 0};
      spd = 0; expChg = 1'b0;
    end else begin
      oldSpd = spd;
      if (p2[2]) spd = 0;
      else if (p2[0] && !p2[1]) spd = (spd < 2) ? spd + 1 : 2;
      else if (p2[1] && !p2[0]) spd = (spd > 0) ? spd - 1 : 0;
      expChg = (spd != oldSpd);
      p2 = p1;
      acc = '0;
      for (int i = 0; i < 3; i++) begin
        if (h2[i] != deb[i]) begin
          run[i]++;
          if (run[i] == DEB) begin
            deb[i] = h2[i];
            run[i] = 0;
            acc[i] = h2[i];
          end
        end else begin
          run[i] = 0;
        end
      end
      p1 = acc;
      h2 = h1;
      h1 = {btn_stop, btn_down, btn_up};
    end
  end

  // Compare against the model every cycle, and check the output invariants:
  // code 11 never appears, and spd_chg is high exactly when {A,B} moved.
  logic [1:0] prevAB  = 2'b00;
  logic       prevRst = 1'b1;

  always @(negedge clk) begin
    checkOutput("model_ab", {6'b0, A, B}, 8'(spd));
    checkOutput("model_chg", {7'b0, spd_chg}, {7'b0, expChg});
    if (!rst && !prevRst) begin
      checkOutput("never_11", {7'b0, ({A, B} == 2'b11)}, 8'd0);
      checkOutput("chg_iff_move", {7'b0, spd_chg}, {7'b0, ({A, B} != prevAB)});
      if (spd_chg) chgSeen++;
    end
    prevAB  = {A, B};
    prevRst = rst;
  end

  task automatic doReset(input int cycles);
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (cycles) begin
      @(negedge clk);
      checkOutput("rst_ab", {6'b0, A, B}, 8'd0);
      checkOutput("rst_chg", {7'b0, spd_chg}, 8'd0);
    end
    rst = 1'b0;
  endtask

  // Hold a button combination for 'hold' cycles, release, and let it settle.
  task automatic applyStimulus(input logic up, input logic down, input logic stop, input int hold);
    btn_up = up; btn_down = down; btn_stop = stop;
    repeat (hold) @(negedge clk);
    btn_up = 1'b0; btn_down = 1'b0; btn_stop = 1'b0;
    repeat (DEB + 6) @(negedge clk);
  endtask

  int c0;

  initial begin
    rst = 1'b1;
    btn_up = 1'b0; btn_down = 1'b0; btn_stop = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Held up button: code 01 appears on edge DEB+4, one pulse, then holds.
    doReset(3);
    c0 = chgSeen;
    btn_up = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      checkOutput("up_lat_ab", {6'b0, A, B}, (i >= DEB + 4) ? 8'd1 : 8'd0);
      checkOutput("up_lat_chg", {7'b0, spd_chg}, (i == DEB + 4) ? 8'd1 : 8'd0);
    end
    checkOutput("up_hold_pulses", 8'(chgSeen - c0), 8'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1);

    // Three separate up presses from STOP saturate at FAST.
    doReset(2);
    c0 = chgSeen;
    applyStimulus(1'b1, 1'b0, 1'b0, DEB + 2);
    checkOutput("up1", {6'b0, A, B}, 8'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, DEB + 2);
    checkOutput("up2", {6'b0, A, B}, 8'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, DEB + 2);
    checkOutput("up3", {6'b0, A, B}, 8'd2);
    checkOutput("up3_pulses", 8'(chgSeen - c0), 8'd2);

    // From FAST: short glitch ignored, then down presses saturate at STOP.
    c0 = chgSeen;
    applyStimulus(1'b0, 1'b1, 1'b0, 2);
    checkOutput("down_glitch", {6'b0, A, B}, 8'd2);
    applyStimulus(1'b0, 1'b1, 1'b0, DEB + 2);
    checkOutput("down1", {6'b0, A, B}, 8'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, DEB + 2);
    checkOutput("down2", {6'b0, A, B}, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, DEB + 2);
    checkOutput("down3", {6'b0, A, B}, 8'd0);
    checkOutput("down_pulses", 8'(chgSeen - c0), 8'd2);

    // Stop beats up on the same edge; up+down together leave SLOW alone.
    applyStimulus(1'b1, 1'b0, 1'b0, DEB + 2);
    applyStimulus(1'b1, 1'b0, 1'b0, DEB + 2);
    checkOutput("to_fast", {6'b0, A, B}, 8'd2);
    applyStimulus(1'b1, 1'b0, 1'b1, DEB + 2);
    checkOutput("stop_prio", {6'b0, A, B}, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, DEB + 2);
    checkOutput("to_slow", {6'b0, A, B}, 8'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, DEB + 2);
    checkOutput("up_down_cancel", {6'b0, A, B}, 8'd1);

    // Reset mid-debounce with up held: aborted, then one fresh press.
    doReset(2);
    btn_up = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("midrst_ab", {6'b0, A, B}, 8'd0);
      checkOutput("midrst_chg", {7'b0, spd_chg}, 8'd0);
    end
    rst = 1'b0;
    for (int i = 1; i <= DEB + 8; i++) begin
      @(negedge clk);
      checkOutput("post_rst_ab", {6'b0, A, B}, (i >= DEB + 4) ? 8'd1 : 8'd0);
      checkOutput("post_rst_chg", {7'b0, spd_chg}, (i == DEB + 4) ? 8'd1 : 8'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1);

    // Randomized button activity, checked cycle by cycle against the model.
    doReset(2);
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 99) < 5) begin
        doReset($urandom_range(1, 3));
      end else begin
        btn_up   = 1'($urandom_range(0, 1));
        btn_down = 1'($urandom_range(0, 2) == 0);
        btn_stop = 1'($urandom_range(0, 5) == 0);
        repeat ($urandom_range(1, DEB + 4)) @(negedge clk);
        btn_up = 1'b0; btn_down = 1'b0; btn_stop = 1'b0;
        repeat ($urandom_range(0, 8)) @(negedge clk);
      end
    end
    repeat (DEB + 8) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/speed_sel_enc.md
SPEED_SEL_ENC -- requirements
Module: speed_sel_enc

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles needed to accept a button level; legal range 2..65535.
REQ-002 clk  input  1  single system clock, all flops rising-edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 btn_up  input  1  raw speed-up button, asynchronous to clk, active-high.
REQ-005 btn_down  input  1  raw speed-down button, asynchronous to clk, active-high.
REQ-006 btn_stop  input  1  raw stop button, asynchronous to clk, active-high.
REQ-007 A  output  1  speed code MSB, drives A of the 7-segment speed decoder.
REQ-008 B  output  1  speed code LSB, drives B of the 7-segment speed decoder.
REQ-009 spd_chg  output  1  one-cycle pulse when {A,B} changes value.

Function
REQ-010 Speed code {A,B}: STOP=00, SLOW=01, FAST=10; 11 never driven.
REQ-011 Each raw button is passed through a 2-flop synchronizer before any other logic.
REQ-012 Debounce: per button, counter resets on any change of the synchronized level versus the debounced level; debounced level takes the new value on the edge where the counter reaches DEBOUNCE_CYCLES; counter saturates, no wrap.
REQ-013 Press event: one-cycle registered pulse on a 0->1 transition of the debounced level; release generates nothing.
REQ-014 Holding a button generates exactly one press event, with no auto-repeat.
REQ-015 FSM states STOP, SLOW, FAST; A and B are decoded directly from state flops (glitch-free, no combinational path from inputs).
REQ-016 up press: STOP->SLOW, SLOW->FAST, FAST stays FAST (saturate).
REQ-017 down press: FAST->SLOW, SLOW->STOP, STOP stays STOP (saturate).
REQ-018 stop press: any state -> STOP; stop has priority over up/down in the same cycle.
REQ-019 Simultaneous up and down press in the same cycle (without stop): no state change.
REQ-020 Latency: {A,B} changes exactly DEBOUNCE_CYCLES+4 rising edges after the first edge that samples the new raw level, given a stable raw input throughout.
REQ-021 spd_chg is asserted in the cycle {A,B} first shows its new value; it is not asserted on saturating presses or on no-change presses.
REQ-022 Glitches on a raw input shorter than DEBOUNCE_CYCLES cycles (after synchronization) produce no press event.

Reset
REQ-023 While rst=1: state=STOP ({A,B}=00), spd_chg=0, synchronizer flops=0, debounced levels=0, counters=0, press pulses=0.
REQ-024 Reset asserted mid-debounce or mid-press aborts it; no pending event survives reset.
REQ-025 A button held through reset deassertion is treated as a new press once debounced (one event).

Structure
REQ-026 Shared package speed_pkg holds the speed-code constants (STOP/SLOW/FAST) and the DEBOUNCE_CYCLES default; the 7-segment speed decoder uses the same constants.
REQ-027 One sub-module btn_debounce (synchronizer + debounce counter + rising-edge pulse), parameterized by DEBOUNCE_CYCLES, instantiated three times.
REQ-028 Counter width = ceil(log2(DEBOUNCE_CYCLES+1)).

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-029 Reset, then btn_up high for 20 cycles -> {A,B}=01 exactly 8 edges after first sampling edge, spd_chg one pulse, stays 01 while held.
REQ-030 From STOP: three separate up presses -> 01, 10, 10; spd_chg pulses only twice.
REQ-031 From FAST: 2-cycle btn_down glitch -> no change; then full down press -> 01; second down press -> 00; third -> 00 with no spd_chg.
REQ-032 From FAST: btn_stop and btn_up raised on the same edge -> {A,B}=00; btn_up and btn_down together from SLOW -> stays 01.
REQ-033 btn_up held, rst pulsed for 3 cycles mid-debounce -> {A,B}=00 during reset; after release, one press -> 01 at DEBOUNCE_CYCLES+4 edges after deassertion.
REQ-034 Assertion over all runs: {A,B} never 11 and output never changes outside a spd_chg cycle.
